swu_param: RTL and testbench

Parametrised sliding-window unit for the ECG front end. It streams `len` words from a synchronous ROM/RAM read port as one continuous MSB-first bit string. It emits WIN_W-bit windows advanced by STRIDE bits, crossing word boundaries seamlessly, over a valid/ready interface to the PE-array input stage. It adds a start/done handshake, runtime length, arbitrary window/stride/word widths, and output backpressure.

---
 rtl/swu_param.sv | 150 +++++++++++++++
 tb/tb_swu_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/swu_param.sv
// Sliding-window unit: streams len memory words as one MSB-first bit string and emits
// WIN_W-bit windows advanced by STRIDE bits over a valid/ready interface.
module swu_param #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 29,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned WIN_W  = 7,
    parameter int unsigned STRIDE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [WORD_W-1:0] mem_rdata_i,
    output logic [WIN_W-1:0]  win_data_o,
    output logic              win_valid_o,
    input  logic              win_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned BufW  = 2 * WORD_W;
    localparam int unsigned FillW = $clog2(BufW + 1);

    localparam logic [FillW-1:0]  WordF   = FillW'(WORD_W);
    localparam logic [FillW-1:0]  WinF    = FillW'(WIN_W);
    localparam logic [FillW-1:0]  StrideF = FillW'(STRIDE);
    // fill below this after an accept means no further full window exists
    localparam logic [FillW-1:0]  LastF   = FillW'(WIN_W + STRIDE);
    localparam logic [ADDR_W:0]   DepthL  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [BufW-1:0]   buf_q, buf_d;
    logic [FillW-1:0]  fill_q, fill_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              rvalid_q, rvalid_d;

    logic              win_valid;
    logic              accept;
    logic              pending;
    logic              last_win;
    logic              issue;
    logic [BufW-1:0]   buf_shift;
    logic [FillW-1:0]  fill_shift;
    logic [BufW-1:0]   load_word;

    // Next-state for the FSM, bit buffer and fetch sequencing
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        fill_d     = fill_q;
        issued_d   = issued_q;
        len_d      = len_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        // memory returns data one cycle after the registered enable
        rvalid_d   = mem_en_q;
        issue      = 1'b0;
        buf_shift  = buf_q;
        fill_shift = fill_q;
        load_word  = {mem_rdata_i, {WORD_W{1'b0}}};

        win_valid = (state_q == StRun) && (fill_q >= WinF);
        accept    = win_valid && win_ready_i;
        pending   = mem_en_q || rvalid_q;
        last_win  = (issued_q == len_q) && !pending && (fill_q < LastF);

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    len_d   = (len_i > DepthL) ? DepthL : len_i;
                    issue   = 1'b1;
                end
            end
            StRun: begin
                issue = (issued_q < len_q) && !pending && (fill_q <= WordF);
                if (accept) begin
                    buf_shift  = buf_q << STRIDE;
                    fill_shift = fill_q - StrideF;
                end
                buf_d  = buf_shift;
                fill_d = fill_shift;
                // new word lands directly below the bits still valid after the shift
                if (rvalid_q) begin
                    buf_d  = buf_shift | (load_word >> fill_shift);
                    fill_d = fill_shift + WordF;
                end
                if (accept && last_win) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d  = StIdle;
                buf_d    = '0;
                fill_d   = '0;
                issued_d = '0;
                len_d    = '0;
                rvalid_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (issue) begin
            mem_en_d   = 1'b1;
            mem_addr_d = issued_q[ADDR_W-1:0];
            issued_d   = issued_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            fill_q     <= '0;
            issued_q   <= '0;
            len_q      <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            issued_q   <= issued_d;
            len_q      <= len_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign mem_en_o    = mem_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign win_data_o  = buf_q[BufW-1 -: WIN_W];
    assign win_valid_o = win_valid;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_swu_param.sv
// Directed bench for swu_param: default-parameter instance plus an 8/8 non-overlapping instance.
module tb_swu_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // default instance
    logic        start_a, mem_en_a, win_valid_a, win_ready_a, busy_a, done_a;
    logic [5:0]  len_a;
    logic [4:0]  mem_addr_a;
    logic [31:0] rdata_a;
    logic [6:0]  win_data_a;
    logic [31:0] mem_a [0:31];

    // WIN_W=8, STRIDE=8 instance
    logic        start_b, mem_en_b, win_valid_b, win_ready_b, busy_b, done_b;
    logic [5:0]  len_b;
    logic [4:0]  mem_addr_b;
    logic [31:0] rdata_b;
    logic [7:0]  win_data_b;
    logic [31:0] mem_b [0:31];

    int checks = 0;
    int errors = 0;
    logic [6:0] got_a [0:511];

    swu_param dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_a),
        .len_i       (len_a),
        .mem_en_o    (mem_en_a),
        .mem_addr_o  (mem_addr_a),
        .mem_rdata_i (rdata_a),
        .win_data_o  (win_data_a),
        .win_valid_o (win_valid_a),
        .win_ready_i (win_ready_a),
        .busy_o      (busy_a),
        .done_o      (done_a)
    );

    swu_param #(
        .WORD_W (32),
        .DEPTH  (29),
        .ADDR_W (5),
        .WIN_W  (8),
        .STRIDE (8)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_b),
        .len_i       (len_b),
        .mem_en_o    (mem_en_b),
        .mem_addr_o  (mem_addr_b),
        .mem_rdata_i (rdata_b),
        .win_data_o  (win_data_b),
        .win_valid_o (win_valid_b),
        .win_ready_i (win_ready_b),
        .busy_o      (busy_b),
        .done_o      (done_b)
    );

    // synchronous read ports: data one cycle after enable
    always @(posedge clk) begin
        if (mem_en_a) rdata_a <= mem_a[mem_addr_a];
        if (mem_en_b) rdata_b <= mem_b[mem_addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // window k of the default instance straight from the stream bit definition
    function automatic logic [6:0] exp_a(input int k);
        logic [6:0] r;
        int b;
        for (int i = 0; i < 7; i++) begin
            b = k * 2 + i;
            r[6-i] = mem_a[b/32][31-(b%32)];
        end
        return r;
    endfunction

    task automatic run_a(input int len, input int rmode, input int mid_at, input int abort_at);
        int k, reads, c, n_exp;
        bit fin, aborted, stalled;
        logic [6:0] held;
        n_exp   = (len * 32 - 7) / 2 + 1;
        k       = 0;
        reads   = 0;
        c       = 0;
        fin     = 1'b0;
        aborted = 1'b0;
        stalled = 1'b0;
        held    = '0;
        start_a = 1'b1;
        len_a   = 6'(len);
        win_ready_a = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_start", {31'd0, busy_a}, 32'd1);
        while (!fin && !aborted && c < 3000) begin
            start_a = 1'b0;
            len_a   = 6'(len);
            if (abort_at > 0 && k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mem_en", {31'd0, mem_en_a}, 32'd0);
                chk("rst_mem_addr", {27'd0, mem_addr_a}, 32'd0);
                chk("rst_win_data", {25'd0, win_data_a}, 32'd0);
                chk("rst_win_valid", {31'd0, win_valid_a}, 32'd0);
                chk("rst_busy", {31'd0, busy_a}, 32'd0);
                chk("rst_done", {31'd0, done_a}, 32'd0);
                @(posedge clk);
                #1;
                chk("rst_no_done", {31'd0, done_a}, 32'd0);
                rst_n   = 1'b1;
                aborted = 1'b1;
            end else begin
                if (c == 1) chk("valid_c1", {31'd0, win_valid_a}, 32'd0);
                if (c == 2) chk("valid_c2", {31'd0, win_valid_a}, 32'd1);
                if (mem_en_a) begin
                    chk("mem_addr", {27'd0, mem_addr_a}, 32'(reads));
                    reads++;
                end
                if (done_a) begin
                    fin = 1'b1;
                    if (rmode == 0) chk("done_cycle", 32'(c), 32'(n_exp + 2));
                end else begin
                    if (win_valid_a) begin
                        if (stalled) chk("stall_stable", {25'd0, win_data_a}, {25'd0, held});
                        win_ready_a = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                        if (win_ready_a) begin
                            if (k < 512) got_a[k] = win_data_a;
                            chk("window", {25'd0, win_data_a}, {25'd0, exp_a(k)});
                            k++;
                            stalled = 1'b0;
                            if (k == mid_at) begin
                                start_a = 1'b1;
                                len_a   = 6'd3;
                            end
                        end else begin
                            stalled = 1'b1;
                            held    = win_data_a;
                        end
                    end
                    @(posedge clk);
                    #1;
                    c++;
                end
            end
        end
        start_a = 1'b0;
        if (!aborted) begin
            if (!fin) begin
                chk("timeout", 32'd0, 32'd1);
            end else begin
                chk("win_count", 32'(k), 32'(n_exp));
                chk("read_count", 32'(reads), 32'(len));
                @(posedge clk);
                #1;
                chk("busy_after_done", {31'd0, busy_a}, 32'd0);
                chk("done_single", {31'd0, done_a}, 32'd0);
            end
        end
    endtask

    logic [7:0] exp_b [0:7];
    logic [7:0] got_b [0:7];
    int nb, db;

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; len_a = '0; win_ready_a = 1'b1;
        start_b = 1'b0; len_b = '0; win_ready_b = 1'b1;
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_en", {31'd0, mem_en_a}, 32'd0);
        chk("reset_mem_addr", {27'd0, mem_addr_a}, 32'd0);
        chk("reset_win_data", {25'd0, win_data_a}, 32'd0);
        chk("reset_win_valid", {31'd0, win_valid_a}, 32'd0);
        chk("reset_busy", {31'd0, busy_a}, 32'd0);
        chk("reset_done", {31'd0, done_a}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single word, 13 windows
        mem_a[0] = 32'hA5A5_A5A5;
        run_a(1, 0, 0, 0);
        chk("len1_first", {25'd0, got_a[0]}, 32'h52);
        chk("len1_last", {25'd0, got_a[12]}, 32'h52);

        // full-length ROM ramp, back-to-back
        for (int i = 0; i < 29; i++) mem_a[i] = i * 32'h0101_0101;
        run_a(29, 0, 0, 0);
        chk("len29_w13", {25'd0, got_a[13]}, 32'h00);
        chk("len29_w18", {25'd0, got_a[18]}, 32'h08);
        chk("len29_last", {25'd0, got_a[460]}, 32'h0E);

        // random backpressure
        run_a(29, 1, 0, 0);

        // start mid-run ignored, then a full rerun
        run_a(29, 0, 50, 0);
        run_a(29, 0, 0, 0);

        // reset at window 100, then clean run
        run_a(29, 0, 0, 100);
        run_a(29, 0, 0, 0);

        // non-overlapping 8/8 windows
        mem_b[0] = 32'h0102_0304;
        mem_b[1] = 32'h0506_0708;
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        start_b = 1'b1;
        len_b   = 6'd2;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        nb = 0;
        db = 0;
        for (int c = 0; c < 40; c++) begin
            if (win_valid_b) begin
                if (nb < 8) got_b[nb] = win_data_b;
                nb++;
            end
            if (done_b) db++;
            @(posedge clk);
            #1;
        end
        chk("b_count", 32'(nb), 32'd8);
        chk("b_done", 32'(db), 32'd1);
        for (int i = 0; i < 8; i++) chk("b_window", {24'd0, got_b[i]}, {24'd0, exp_b[i]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
